// File: rtl/slave_axi_4_lite_sram.sv
// AXI4-lite slave backed by a register-array SRAM.
// Independent write and read FSMs; reads have a configurable fixed latency.
module slave_axi_4_lite_sram #(
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ADDR_WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                        AXI_ACLK,
  input  logic                        AXI_ARESET,
  input  logic [AXI_ADDR_WIDTH-1:0]   AXI_AWADDR,
  input  logic [2:0]                  AXI_AWPROT,
  input  logic                        AXI_AWVALID,
  output logic                        AXI_AWREADY,
  input  logic [AXI_DATA_WIDTH-1:0]   AXI_WDATA,
  input  logic [AXI_DATA_WIDTH/8-1:0] AXI_WSTRB,
  input  logic                        AXI_WVALID,
  output logic                        AXI_WREADY,
  output logic [1:0]                  AXI_BRESP,
  output logic                        AXI_BVALID,
  input  logic                        AXI_BREADY,
  input  logic [AXI_ADDR_WIDTH-1:0]   AXI_ARADDR,
  input  logic [2:0]                  AXI_ARPROT,
  input  logic                        AXI_ARVALID,
  output logic                        AXI_ARREADY,
  output logic [AXI_DATA_WIDTH-1:0]   AXI_RDATA,
  output logic [1:0]                  AXI_RRESP,
  output logic                        AXI_RVALID,
  input  logic                        AXI_RREADY
);

  localparam int unsigned BYTES = AXI_DATA_WIDTH / 8;
  localparam int unsigned OFFW  = $clog2(BYTES);
  localparam int unsigned IDXW  = $clog2(DEPTH);
  localparam logic [AXI_ADDR_WIDTH:0] MEM_BYTES =
    (AXI_ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [3:0] LAT = 4'(READ_LATENCY);
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  if (READ_LATENCY > 15) begin : g_bad_latency
    $error("READ_LATENCY must be in 0..15");
  end
  if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two");
  end

  typedef enum logic {
    W_IDLE,
    W_RESP
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_DATA
  } r_state_e;

  logic [AXI_DATA_WIDTH-1:0] mem_q [DEPTH];

  w_state_e                  w_state_q;
  logic                      aw_ready_q;
  logic                      w_ready_q;
  logic                      aw_got_q;
  logic                      w_got_q;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
  logic [AXI_DATA_WIDTH-1:0] w_data_q;
  logic [BYTES-1:0]          w_strb_q;
  logic                      b_valid_q;
  logic [1:0]                b_resp_q;

  r_state_e                  r_state_q;
  logic                      ar_ready_q;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr_q;
  logic [3:0]                cnt_q;
  logic                      r_valid_q;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic [1:0]                r_resp_q;

  logic                      aw_hs;
  logic                      w_hs;
  logic                      wr_en;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr;
  logic [AXI_ADDR_WIDTH-1:0] wr_off;
  logic [AXI_DATA_WIDTH-1:0] wr_data;
  logic [BYTES-1:0]          wr_strb;
  logic                      wr_ok;
  logic [IDXW-1:0]           wr_idx;

  logic                      ar_hs;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr;
  logic [AXI_ADDR_WIDTH-1:0] rd_off;
  logic                      rd_ok;
  logic [IDXW-1:0]           rd_idx;

  logic                      unused_ok;

  assign unused_ok = ^{AXI_AWPROT, AXI_ARPROT};

  // A write commits on the edge where the later of AW/W completes;
  // whichever channel completes at that edge supplies its live values.
  assign aw_hs   = AXI_AWVALID && aw_ready_q;
  assign w_hs    = AXI_WVALID && w_ready_q;
  assign wr_en   = (w_state_q == W_IDLE) && !AXI_ARESET
                && (aw_got_q || aw_hs) && (w_got_q || w_hs);
  assign wr_addr = aw_got_q ? aw_addr_q : AXI_AWADDR;
  assign wr_data = w_got_q ? w_data_q : AXI_WDATA;
  assign wr_strb = w_got_q ? w_strb_q : AXI_WSTRB;
  assign wr_off  = wr_addr - BASE_ADDR;
  assign wr_ok   = (wr_addr >= BASE_ADDR) && ({1'b0, wr_off} < MEM_BYTES);
  assign wr_idx  = wr_off[OFFW +: IDXW];

  // Zero-latency reads capture straight from the live AR address.
  assign ar_hs   = AXI_ARVALID && ar_ready_q;
  assign rd_addr = (r_state_q == R_IDLE) ? AXI_ARADDR : ar_addr_q;
  assign rd_off  = rd_addr - BASE_ADDR;
  assign rd_ok   = (rd_addr >= BASE_ADDR) && ({1'b0, rd_off} < MEM_BYTES);
  assign rd_idx  = rd_off[OFFW +: IDXW];

  // Byte-enabled memory write; contents survive reset.
  always_ff @(posedge AXI_ACLK) begin
    if (wr_en && wr_ok) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_strb[i]) begin
          mem_q[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
        end
      end
    end
  end

  // Write FSM: collect AW and W in any order, then hold the response.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      w_state_q  <= W_IDLE;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      aw_got_q   <= 1'b0;
      w_got_q    <= 1'b0;
      aw_addr_q  <= '0;
      w_data_q   <= '0;
      w_strb_q   <= '0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= OKAY;
    end else begin
      unique case (w_state_q)
        W_IDLE: begin
          if (wr_en) begin
            w_state_q  <= W_RESP;
            b_valid_q  <= 1'b1;
            b_resp_q   <= wr_ok ? OKAY : SLVERR;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            aw_got_q   <= 1'b0;
            w_got_q    <= 1'b0;
          end else begin
            if (aw_hs) begin
              aw_addr_q  <= AXI_AWADDR;
              aw_got_q   <= 1'b1;
              aw_ready_q <= 1'b0;
            end else if (!aw_got_q) begin
              aw_ready_q <= 1'b1;
            end
            if (w_hs) begin
              w_data_q  <= AXI_WDATA;
              w_strb_q  <= AXI_WSTRB;
              w_got_q   <= 1'b1;
              w_ready_q <= 1'b0;
            end else if (!w_got_q) begin
              w_ready_q <= 1'b1;
            end
          end
        end
        W_RESP: begin
          if (AXI_BREADY) begin
            w_state_q  <= W_IDLE;
            b_valid_q  <= 1'b0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  // Read FSM: accept AR, wait READ_LATENCY cycles, capture, hold data.
  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state_q  <= R_IDLE;
      ar_ready_q <= 1'b0;
      ar_addr_q  <= '0;
      cnt_q      <= '0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
    end else begin
      unique case (r_state_q)
        R_IDLE: begin
          if (ar_hs) begin
            ar_ready_q <= 1'b0;
            ar_addr_q  <= AXI_ARADDR;
            if (READ_LATENCY == 0) begin
              r_state_q <= R_DATA;
              r_valid_q <= 1'b1;
              r_data_q  <= rd_ok ? mem_q[rd_idx] : '0;
              r_resp_q  <= rd_ok ? OKAY : SLVERR;
            end else begin
              cnt_q     <= LAT;
              r_state_q <= R_WAIT;
            end
          end else begin
            ar_ready_q <= 1'b1;
          end
        end
        R_WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            r_state_q <= R_DATA;
            r_valid_q <= 1'b1;
            r_data_q  <= rd_ok ? mem_q[rd_idx] : '0;
            r_resp_q  <= rd_ok ? OKAY : SLVERR;
          end
        end
        R_DATA: begin
          if (AXI_RREADY) begin
            r_state_q  <= R_IDLE;
            r_valid_q  <= 1'b0;
            ar_ready_q <= 1'b1;
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign AXI_AWREADY = aw_ready_q;
  assign AXI_WREADY  = w_ready_q;
  assign AXI_BVALID  = b_valid_q;
  assign AXI_BRESP   = b_resp_q;
  assign AXI_ARREADY = ar_ready_q;
  assign AXI_RVALID  = r_valid_q;
  assign AXI_RDATA   = r_data_q;
  assign AXI_RRESP   = r_resp_q;

endmodule

// File: tb/tb_slave_axi_4_lite_sram.sv
// Bench for slave_axi_4_lite_sram: random AXI4-lite traffic against
// a word-array model, plus reset-in-flight on a latency-4 instance.
module tb_slave_axi_4_lite_sram;

  localparam int DEPTH = 1024;
  localparam int LAT   = 1;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid, awready;
  logic [63:0] wdata;
  logic [7:0]  wstrb;
  logic        wvalid, wready;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid, arready;
  logic [63:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid, rready;

  logic        rst4;
  logic [31:0] araddr4;
  logic        arvalid4, arready4, rvalid4;
  logic [63:0] rdata4;
  logic [1:0]  rresp4, bresp4;
  logic        awready4, wready4, bvalid4;

  slave_axi_4_lite_sram #(.READ_LATENCY(LAT)) u_dut (
    .AXI_ACLK(clk), .AXI_ARESET(rst),
    .AXI_AWADDR(awaddr), .AXI_AWPROT(awprot),
    .AXI_AWVALID(awvalid), .AXI_AWREADY(awready),
    .AXI_WDATA(wdata), .AXI_WSTRB(wstrb),
    .AXI_WVALID(wvalid), .AXI_WREADY(wready),
    .AXI_BRESP(bresp), .AXI_BVALID(bvalid), .AXI_BREADY(bready),
    .AXI_ARADDR(araddr), .AXI_ARPROT(arprot),
    .AXI_ARVALID(arvalid), .AXI_ARREADY(arready),
    .AXI_RDATA(rdata), .AXI_RRESP(rresp),
    .AXI_RVALID(rvalid), .AXI_RREADY(rready)
  );

  slave_axi_4_lite_sram #(.READ_LATENCY(4)) u_dut4 (
    .AXI_ACLK(clk), .AXI_ARESET(rst4),
    .AXI_AWADDR(32'h0), .AXI_AWPROT(3'b0),
    .AXI_AWVALID(1'b0), .AXI_AWREADY(awready4),
    .AXI_WDATA(64'h0), .AXI_WSTRB(8'h0),
    .AXI_WVALID(1'b0), .AXI_WREADY(wready4),
    .AXI_BRESP(bresp4), .AXI_BVALID(bvalid4), .AXI_BREADY(1'b1),
    .AXI_ARADDR(araddr4), .AXI_ARPROT(3'b0),
    .AXI_ARVALID(arvalid4), .AXI_ARREADY(arready4),
    .AXI_RDATA(rdata4), .AXI_RRESP(rresp4),
    .AXI_RVALID(rvalid4), .AXI_RREADY(1'b1)
  );

  int total = 0;
  int bad = 0;
  logic [63:0] mem_m [DEPTH];

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit m_ok(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < 32'(DEPTH * 8));
  endfunction

  function automatic int m_idx(input logic [31:0] a);
    return int'((a - BASE) / 8);
  endfunction

  task automatic do_write(input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input int awd,
                          input int wd, input int hold);
    bit awdn, wdn, hs_aw, hs_w;
    int cyc;
    logic [1:0] er;
    awdn = 0; wdn = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    bready = (hold == 0);
    while (!(awdn && wdn) && cyc < 40) begin
      awvalid = !awdn && cyc >= awd;
      wvalid  = !wdn && cyc >= wd;
      chk("b_early", bvalid, 0);
      if (awdn) chk("aw_drop", awready, 0);
      if (wdn) chk("w_drop", wready, 0);
      if (awdn && !wdn) chk("w_wait_rdy", wready, 1);
      if (wdn && !awdn) chk("aw_wait_rdy", awready, 1);
      hs_aw = awvalid && awready;
      hs_w  = wvalid && wready;
      tick();
      awdn |= hs_aw;
      wdn  |= hs_w;
      cyc++;
    end
    awvalid = 0;
    wvalid  = 0;
    chk("wr_hs", {awdn, wdn}, 2'b11);
    er = m_ok(a) ? 2'b00 : 2'b10;
    if (m_ok(a)) begin
      for (int i = 0; i < 8; i++) begin
        if (s[i]) mem_m[m_idx(a)][8*i +: 8] = d[8*i +: 8];
      end
    end
    chk("bvalid", bvalid, 1);
    chk("bresp", bresp, er);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("b_hold_v", bvalid, 1);
      chk("b_hold_r", bresp, er);
      chk("b_hold_awr", awready, 0);
    end
    bready = 1;
    tick();
    chk("b_done", bvalid, 0);
    chk("b_rdy", {awready, wready}, 2'b11);
  endtask

  task automatic do_read(input logic [31:0] a, input int hold);
    bit hs;
    int n;
    logic [63:0] ed;
    logic [1:0] er;
    ed = m_ok(a) ? mem_m[m_idx(a)] : 64'h0;
    er = m_ok(a) ? 2'b00 : 2'b10;
    araddr = a;
    arvalid = 1;
    rready = (hold == 0);
    hs = 0; n = 0;
    while (!hs && n < 40) begin
      hs = arready;
      tick();
      n++;
    end
    arvalid = 0;
    chk("ar_hs", hs, 1);
    n = 1;
    while (!rvalid && n < 40) begin
      chk("ar_low", arready, 0);
      tick();
      n++;
    end
    chk("r_lat", n, LAT + 1);
    chk("rdata", rdata, ed);
    chk("rresp", rresp, er);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("r_hold_v", rvalid, 1);
      chk("r_hold_d", rdata, ed);
      chk("r_hold_r", rresp, er);
      chk("r_hold_arr", arready, 0);
    end
    rready = 1;
    tick();
    chk("r_done", rvalid, 0);
    chk("r_arr", arready, 1);
  endtask

  function automatic logic [31:0] rand_addr();
    int k;
    k = $urandom_range(0, 16);
    if ($urandom_range(0, 7) == 0) begin
      case ($urandom_range(0, 3))
        0: return BASE - 32'(8 * $urandom_range(1, 4));
        1: return BASE + 32'(DEPTH * 8) + 32'(8 * $urandom_range(0, 3));
        2: return 32'($urandom_range(32'h7FFF_FFFF, 0));
        default: return 32'hFFFF_FFF8;
      endcase
    end
    if (k == 16) k = DEPTH - 1;
    return BASE + 32'(k * 8) + 32'($urandom_range(0, 7));
  endfunction

  initial begin
    bit seen;
    rst = 1; rst4 = 1;
    awaddr = 0; awprot = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wvalid = 0; bready = 0;
    araddr = 0; arprot = 0; arvalid = 0; rready = 0;
    araddr4 = 0; arvalid4 = 0;
    tick();
    tick();
    chk("rst_rdy", {awready, wready, arready}, 3'b000);
    chk("rst_valid", {bvalid, rvalid}, 2'b00);
    chk("rst_resp", {bresp, rresp}, 4'b0);
    chk("rst_rdata", rdata, 0);
    rst = 0; rst4 = 0;
    tick();
    chk("post_rst_rdy", {awready, wready, arready}, 3'b111);

    for (int k = 0; k <= 16; k++) begin
      do_write(BASE + 32'(((k == 16) ? DEPTH - 1 : k) * 8),
               {$urandom, $urandom}, 8'hFF, 0, 0, 0);
    end

    do_write(BASE + 32'h8, 64'h1122334455667788, 8'hFF, 0, 0, 0);
    do_read(BASE + 32'h8, 0);
    do_write(BASE + 32'h8, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 0, 0, 0);
    do_read(BASE + 32'h8, 0);
    chk("partial_lit", rdata, 64'h11223344AAAAAAAA);

    do_write(BASE + 32'h10, 64'h0123456789ABCDEF, 8'hFF, 0, 3, 0);
    do_write(BASE + 32'h18, 64'hFEDCBA9876543210, 8'hFF, 3, 0, 0);
    do_read(BASE + 32'h10, 0);
    do_read(BASE + 32'h18, 0);

    do_write(32'h7FFF_FFF8, 64'hDEADBEEFDEADBEEF, 8'hFF, 0, 0, 0);
    do_read(BASE + 32'(8 * (DEPTH - 1)), 0);
    do_read(BASE + 32'h8, 0);
    do_read(BASE + 32'(DEPTH * 8), 0);

    do_write(BASE + 32'h20, 64'h5A5A_0F0F_A5A5_F0F0, 8'hFF, 0, 0, 5);
    do_read(BASE + 32'h20, 5);

    fork
      do_write(BASE + 32'h28, 64'hCAFEF00D12345678, 8'hFF, 1, 0, 0);
      do_read(BASE + 32'h30, 0);
    join

    for (int it = 0; it < 80; it++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_write(rand_addr(), {$urandom, $urandom},
                 8'($urandom_range(0, 255)), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 2));
      end else begin
        do_read(rand_addr(), $urandom_range(0, 2));
      end
    end

    araddr4 = BASE;
    arvalid4 = 1;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      seen = arready4;
      tick();
    end
    arvalid4 = 0;
    chk("l4_ar_hs", seen, 1);
    tick();
    chk("l4_wait", rvalid4, 0);
    rst4 = 1;
    tick();
    chk("l4_rst_rv", rvalid4, 0);
    chk("l4_rst_arr", arready4, 0);
    tick();
    rst4 = 0;
    tick();
    chk("l4_rel_arr", arready4, 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      seen |= rvalid4;
    end
    chk("l4_stale_rv", seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
